// File: rtl/fifo_stream_reader.sv
// Read-side engine: pops a synchronous fifo into a 3-entry buffer and presents it as an AXI-Stream master framed into bursts.
// Optional macro FIFO_STREAM_READER_PARITY_EN adds m_tparity, the even parity of each word stored with it.
module fifo_stream_reader #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             fifo_empty,
  output logic             r_ready,
  input  logic [WIDTH-1:0] data_out,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic [CNT_W-1:0] beat_cnt
`ifdef FIFO_STREAM_READER_PARITY_EN
  ,
  output logic             m_tparity
`endif
);

  logic [1:0]       r_held;
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic             r_inflight;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_len;
  logic [WIDTH-1:0] r_mem [0:2];

  logic             w_capture;
  logic             w_xfer;
  logic             w_room;
  logic [1:0]       w_wptr_next;
  logic [1:0]       w_rptr_next;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_len_load;

  // A slot is reserved for every word already popped, so the buffer can never overflow.
  assign w_room      = ({1'b0, r_held} + {2'b00, r_inflight}) <= 3'd2;
  assign r_ready     = reset & en & ~fifo_empty & w_room;

  assign w_capture   = r_inflight;
  assign m_tvalid    = (r_held != 2'd0);
  assign w_xfer      = m_tvalid & m_tready;
  assign m_tdata     = m_tvalid ? r_mem[r_rptr] : '0;
  assign m_tlast     = m_tvalid & (r_beat == (r_len - CNT_W'(1)));
  assign beat_cnt    = r_beat;

  assign w_wptr_next = (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
  assign w_rptr_next = (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
  assign w_len_eff   = (burst_len == '0) ? CNT_W'(1) : burst_len;

  // The length is taken at the start of beat 0 (burst wrap or idle) so that m_tlast of a
  // stalled beat-0 word cannot change, and the whole burst uses one length.
  assign w_len_load  = (w_xfer & m_tlast) | ((r_beat == '0) & ~m_tvalid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held     <= 2'd0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_len      <= CNT_W'(1);
    end else begin
      r_inflight <= r_ready;
      r_held     <= r_held + {1'b0, w_capture} - {1'b0, w_xfer};
      if (w_capture) begin
        r_wptr <= w_wptr_next;
      end
      if (w_xfer) begin
        r_rptr <= w_rptr_next;
        r_beat <= m_tlast ? '0 : r_beat + CNT_W'(1);
      end
      if (w_len_load) begin
        r_len <= w_len_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wptr] <= data_out;
    end
  end

`ifdef FIFO_STREAM_READER_PARITY_EN
  logic r_par [0:2];

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_par[r_wptr] <= ^data_out;
    end
  end

  assign m_tparity = m_tvalid & r_par[r_rptr];
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural fifo and a transfer recorder.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] burst_len;
  logic        fifo_empty;
  logic        r_ready;
  logic [31:0] data_out;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [15:0] beat_cnt;
`ifdef FIFO_STREAM_READER_PARITY_EN
  logic        m_tparity;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .r_ready    (r_ready),
    .data_out   (data_out),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .beat_cnt   (beat_cnt)
`ifdef FIFO_STREAM_READER_PARITY_EN
    ,
    .m_tparity  (m_tparity)
`endif
  );

  // behavioural fifo sharing the reset
  logic [31:0] fmem [0:255];
  logic [7:0]  f_wr = 8'd0;
  logic [7:0]  f_rd;
  assign fifo_empty = (f_wr == f_rd);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rd     <= f_wr;
      data_out <= 32'd0;
    end else if (r_ready) begin
      data_out <= fmem[f_rd];
      f_rd     <= f_rd + 8'd1;
    end
  end

  // recorder of pops and transfers, plus an independent occupancy model
  int          cyc = 0;
  int          ovf_cnt = 0;
  int          held_m;
  logic        infl_m;
  int          pop_c [$];
  logic [31:0] got_d [$];
  logic        got_l [$];
  logic [15:0] got_b [$];
  int          got_c [$];
  logic        got_p [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_m <= 0;
      infl_m <= 1'b0;
    end else begin
      if (infl_m && held_m == 3 && !(m_tvalid && m_tready)) ovf_cnt <= ovf_cnt + 1;
      held_m <= held_m + (infl_m ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
      infl_m <= r_ready;
      if (r_ready) pop_c.push_back(cyc);
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
        got_b.push_back(beat_cnt);
        got_c.push_back(cyc);
`ifdef FIFO_STREAM_READER_PARITY_EN
        got_p.push_back(m_tparity);
`else
        got_p.push_back(1'b0);
`endif
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] v);
    fmem[f_wr] = v;
    f_wr = f_wr + 8'd1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    m_tready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  int bp, bg;
  logic [7:0] tl;

  initial begin
    reset = 1'b0;
    en = 1'b0;
    burst_len = 16'd4;
    m_tready = 1'b0;
    repeat (3) tick();
    chk("rst_r_ready",  32'(r_ready),  32'd0);
    chk("rst_tvalid",   32'(m_tvalid), 32'd0);
    chk("rst_tdata",    m_tdata,       32'd0);
    chk("rst_tlast",    32'(m_tlast),  32'd0);
    chk("rst_beat",     32'(beat_cnt), 32'd0);
`ifdef FIFO_STREAM_READER_PARITY_EN
    chk("rst_parity",   32'(m_tparity), 32'd0);
`endif
    reset = 1'b1;

    // empty hold
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("empty_hold", 32'({r_ready, m_tvalid, beat_cnt}), 32'd0);
    end

    // streaming 0..7, burst of 4
    en = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'(i));
    bp = pop_c.size();
    bg = got_d.size();
    en = 1'b1;
    repeat (14) tick();
    chk("stream_pops", 32'(pop_c.size() - bp), 32'd8);
    chk("stream_xfers", 32'(got_d.size() - bg), 32'd8);
    chk("stream_pop_span", 32'(pop_c[bp+7] - pop_c[bp]), 32'd7);
    chk("stream_xfer_span", 32'(got_c[bg+7] - got_c[bg]), 32'd7);
    chk("stream_latency", 32'(got_c[bg] - pop_c[bp]), 32'd2);
    tl = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      chk("stream_data", got_d[bg+i], 32'(i));
      chk("stream_tlast", 32'(got_l[bg+i]), 32'(tl[i]));
    end
    chk("stream_beat_end", 32'(beat_cnt), 32'd0);

    // backpressure
    do_reset();
    for (int i = 0; i < 6; i++) push(32'hA0 + 32'(i));
    bp = pop_c.size();
    bg = got_d.size();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 2) begin
        chk("bp_tvalid", 32'(m_tvalid), 32'd1);
        chk("bp_tdata_stable", m_tdata, 32'hA0);
      end
    end
    chk("bp_pops", 32'(pop_c.size() - bp), 32'd3);
    chk("bp_r_ready", 32'(r_ready), 32'd0);
    m_tready = 1'b1;
    repeat (12) tick();
    chk("bp_xfers", 32'(got_d.size() - bg), 32'd6);
    for (int i = 0; i < 6; i++) chk("bp_data", got_d[bg+i], 32'hA0 + 32'(i));
    chk("bp_beat_end", 32'(beat_cnt), 32'd2);

    // pause and length change
    do_reset();
    burst_len = 16'd3;
    m_tready = 1'b1;
    push(32'h10);
    push(32'h11);
    bg = got_d.size();
    en = 1'b1;
    repeat (6) tick();
    chk("pause_beat", 32'(beat_cnt), 32'd2);
    en = 1'b0;
    for (int i = 2; i < 8; i++) push(32'h10 + 32'(i));
    bp = pop_c.size();
    repeat (4) tick();
    chk("pause_no_pops", 32'(pop_c.size() - bp), 32'd0);
    chk("pause_beat_held", 32'(beat_cnt), 32'd2);
    burst_len = 16'd5;
    en = 1'b1;
    repeat (14) tick();
    chk("pause_xfers", 32'(got_d.size() - bg), 32'd8);
    tl = 8'b1000_0100;
    for (int i = 0; i < 8; i++) begin
      chk("pause_data", got_d[bg+i], 32'h10 + 32'(i));
      chk("pause_tlast", 32'(got_l[bg+i]), 32'(tl[i]));
    end
    burst_len = 16'd0;
    bg = got_d.size();
    for (int i = 0; i < 3; i++) push(32'h20 + 32'(i));
    repeat (8) tick();
    chk("len0_xfers", 32'(got_d.size() - bg), 32'd3);
    for (int i = 0; i < 3; i++) chk("len0_tlast", 32'(got_l[bg+i]), 32'd1);
    chk("len0_beat", 32'(beat_cnt), 32'd0);

    // asynchronous reset mid-stream
    do_reset();
    burst_len = 16'd4;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h30 + 32'(i));
    en = 1'b1;
    repeat (3) tick();
    m_tready = 1'b0;
    tick();
    chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    chk("pre_rst_beat", 32'(beat_cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("async_rst_r_ready", 32'(r_ready), 32'd0);
    chk("async_rst_beat", 32'(beat_cnt), 32'd0);
    chk("async_rst_tdata", m_tdata, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    m_tready = 1'b1;
    bg = got_d.size();
    push(32'h55);
    repeat (6) tick();
    chk("post_rst_xfers", 32'(got_d.size() - bg), 32'd1);
    chk("post_rst_data", got_d[bg], 32'h55);
    chk("post_rst_beat", 32'(got_b[bg]), 32'd0);

`ifdef FIFO_STREAM_READER_PARITY_EN
    do_reset();
    burst_len = 16'd4;
    m_tready = 1'b1;
    bg = got_d.size();
    push(32'h0000_0001);
    push(32'h0000_0003);
    push(32'hFFFF_FFFF);
    en = 1'b1;
    repeat (8) tick();
    chk("par_xfers", 32'(got_d.size() - bg), 32'd3);
    chk("par_w1", 32'(got_p[bg]), 32'd1);
    chk("par_w3", 32'(got_p[bg+1]), 32'd0);
    chk("par_wff", 32'(got_p[bg+2]), 32'd0);
`endif

    chk("no_overflow", 32'(ovf_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
